// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types, constants and the CRC-32 byte step for the
// GMII receive framer.
//   rx_state_t    - framer states (IDLE / PRE / DATA / DROP)
//   ETH_PREAMBLE  - preamble byte
//   ETH_SFD       - start-of-frame delimiter
//   CRC32_INIT    - CRC register start value
//   CRC32_RESIDUE - good-frame residue, written MSB-first (normal bit order)
//   crc32_byte()  - one-byte step of the reflected CRC-32 (poly 0xEDB88320)
//   bit_rev32()   - reverses the bit order of a 32-bit word
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/gmii_byte_packer.sv
// gmii_byte_packer: packs a byte stream into DATA_W-bit words, lane 0 first.
//   clk, rst      - clock, synchronous active-high reset
//   start         - SFD seen: clear the lane counter, arm the sop marker
//   push          - data_byte is a frame byte
//   last          - data_byte is the final byte of the frame
//   data_byte     - byte to pack
//   word_valid    - one-cycle word strobe
//   word_data     - packed word; lanes past the last byte read as 0
//   word_keep     - filled lanes, contiguous from lane 0
//   word_sop      - first word after start
//   word_eop      - word holding the last byte
module gmii_byte_packer
    import eth_rx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                push,
    input  logic                last,
    input  logic [7:0]          data_byte,
    output logic                word_valid,
    output logic [DATA_W-1:0]   word_data,
    output logic [DATA_W/8-1:0] word_keep,
    output logic                word_sop,
    output logic                word_eop
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [LANES-1:0]  keep_next;
    logic              sop_pend;
    logic              full;

    always_comb begin
        acc_next = acc;
        acc_next[{lane, 3'b000} +: 8] = data_byte;
        for (int i = 0; i < LANES; i++)
            keep_next[i] = (i <= int'(lane));
        full = (lane == LANE_W'(LANES - 1));
    end

    // acc is cleared after every emitted word, so lanes beyond the last byte
    // of a short final word are already zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            acc        <= '0;
            sop_pend   <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_keep  <= '0;
            word_sop   <= 1'b0;
            word_eop   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            word_sop   <= 1'b0;
            word_eop   <= 1'b0;
            if (start) begin
                lane     <= '0;
                acc      <= '0;
                sop_pend <= 1'b1;
            end else if (push) begin
                if (full || last) begin
                    word_valid <= 1'b1;
                    word_data  <= acc_next;
                    word_keep  <= keep_next;
                    word_sop   <= sop_pend;
                    word_eop   <= last;
                    sop_pend   <= 1'b0;
                    lane       <= '0;
                    acc        <= '0;
                end else begin
                    acc  <= acc_next;
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: GMII receive frame delineator. Strips preamble/SFD, packs
// DA..FCS into DATA_W words, checks FCS, length and rx_er, counts frames.
//   clk, rst                 - gmii_rx_clk, synchronous active-high reset
//   gmii_rx_dv/er, gmii_rxd  - GMII receive inputs
//   out_valid/data/keep      - packed word stream, no backpressure
//   out_sop, out_eop         - first / last word of a frame
//   out_err                  - frame bad, qualified by out_eop
//   frame_len                - byte length of the last frame (saturating)
//   good_cnt, bad_cnt        - frame counters (wrapping)
module gmii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gmii_rx_dv,
    input  logic                gmii_rx_er,
    input  logic [7:0]          gmii_rxd,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_sop,
    output logic                out_eop,
    output logic                out_err,
    output logic [15:0]         frame_len,
    output logic [CNT_W-1:0]    good_cnt,
    output logic [CNT_W-1:0]    bad_cnt
);
    rx_state_t   state;
    logic        dv_d, er_d;
    logic [7:0]  rxd_d;
    logic [31:0] crc;
    logic [15:0] len;
    logic        err_sticky;

    logic        in_data, is_last, start;
    logic [31:0] crc_next;
    logic [15:0] len_next;
    logic        err_next;

    // The live gmii_rx_dv is one byte ahead of rxd_d, so its fall marks
    // rxd_d as the final byte of the frame.
    always_comb begin
        in_data  = (state == DATA) && dv_d;
        is_last  = in_data && !gmii_rx_dv;
        start    = (state == PRE) && dv_d && (rxd_d == ETH_SFD);
        crc_next = crc32_byte(crc, rxd_d);
        len_next = (len == 16'hFFFF) ? len : len + 16'd1;
        // The residue constant is in normal bit order; the shift-right
        // register holds it bit-reversed.
        err_next = err_sticky || er_d
                || (bit_rev32(crc_next) != CRC32_RESIDUE)
                || (int'(len_next) < MIN_LEN)
                || (int'(len_next) > MAX_LEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_d       <= 1'b0;
            er_d       <= 1'b0;
            rxd_d      <= '0;
            state      <= IDLE;
            crc        <= CRC32_INIT;
            len        <= '0;
            err_sticky <= 1'b0;
            out_err    <= 1'b0;
            frame_len  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            dv_d    <= gmii_rx_dv;
            er_d    <= gmii_rx_er;
            rxd_d   <= gmii_rxd;
            out_err <= 1'b0;
            case (state)
                IDLE: if (dv_d) state <= (rxd_d == ETH_PREAMBLE) ? PRE : DROP;
                PRE: begin
                    if (!dv_d)                      state <= IDLE;
                    else if (rxd_d == ETH_PREAMBLE) state <= PRE;
                    else if (rxd_d == ETH_SFD) begin
                        state      <= DATA;
                        crc        <= CRC32_INIT;
                        len        <= '0;
                        err_sticky <= 1'b0;
                    end else                        state <= DROP;
                end
                DATA: begin
                    if (!dv_d) begin
                        // dv fell right after the SFD: nothing to emit,
                        // but the frame had started.
                        state   <= IDLE;
                        bad_cnt <= bad_cnt + CNT_W'(1);
                    end else begin
                        crc        <= crc_next;
                        len        <= len_next;
                        err_sticky <= err_sticky | er_d;
                        if (is_last) begin
                            state     <= IDLE;
                            out_err   <= err_next;
                            frame_len <= len_next;
                            if (err_next) bad_cnt  <= bad_cnt + CNT_W'(1);
                            else          good_cnt <= good_cnt + CNT_W'(1);
                        end
                    end
                end
                DROP: if (!dv_d) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    gmii_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .push       (in_data),
        .last       (is_last),
        .data_byte  (rxd_d),
        .word_valid (out_valid),
        .word_data  (out_data),
        .word_keep  (out_keep),
        .word_sop   (out_sop),
        .word_eop   (out_eop)
    );

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Scoreboard bench for gmii_rx_framer at DATA_W=32: the stimulus pushes the
// expected words of each frame, a negedge monitor pops and compares them.
module tb_gmii_rx_framer;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              gmii_rx_dv = 1'b0;
    logic              gmii_rx_er = 1'b0;
    logic [7:0]        gmii_rxd = 8'h00;
    logic              out_valid, out_sop, out_eop, out_err;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_keep;
    logic [15:0]       frame_len;
    logic [CNT_W-1:0]  good_cnt, bad_cnt;

    always #5 clk = ~clk;

    gmii_rx_framer #(.DATA_W(DATA_W), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
        .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
        .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        sop, eop, err;
        logic [15:0] len;
        logic [31:0] good, bad;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] fr[0:2047];
    int         fr_len = 0;
    int         exp_good = 0;
    int         exp_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Payload pattern plus a standard Ethernet FCS appended LSB first.
    task automatic make_frame(input int n_pay, input int seed);
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n_pay; i++) begin
            fr[i] = 8'(i * seed + 17);
            crc   = crc_step(crc, fr[i]);
        end
        crc = ~crc;
        fr[n_pay]   = crc[7:0];
        fr[n_pay+1] = crc[15:8];
        fr[n_pay+2] = crc[23:16];
        fr[n_pay+3] = crc[31:24];
        fr_len = n_pay + 4;
    endtask

    task automatic push_expect(input logic err, input int max_words);
        exp_t e;
        int   words;
        words = (fr_len + 3) / 4;
        for (int w = 0; w < words && w < max_words; w++) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < 4; l++)
                if (w * 4 + l < fr_len) begin
                    e.data[l*8 +: 8] = fr[w*4+l];
                    e.keep[l] = 1'b1;
                end
            e.sop = (w == 0);
            e.eop = (w == words - 1);
            e.err = err;
            e.len = 16'(fr_len);
            if (e.eop) begin
                if (err) exp_bad++;
                else     exp_good++;
            end
            e.good = 32'(exp_good);
            e.bad  = 32'(exp_bad);
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic r);
        @(negedge clk);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        rst        = r;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sop"},   64'(out_sop),   64'd0);
        chk({tag, "_eop"},   64'(out_eop),   64'd0);
        chk({tag, "_err"},   64'(out_err),   64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_keep"},  64'(out_keep),  64'd0);
        chk({tag, "_len"},   64'(frame_len), 64'd0);
        chk({tag, "_good"},  64'(good_cnt),  64'd0);
        chk({tag, "_bad"},   64'(bad_cnt),   64'd0);
    endtask

    task automatic send(input int er_idx, input int rst_idx, input int gap);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'hD5, 1'b0);
        for (int i = 0; i < fr_len; i++) begin
            drive(1'b1, i == er_idx, fr[i], i == rst_idx);
            if (rst_idx >= 0 && i == rst_idx + 1) begin
                check_reset_state("midreset");
                exp_good = 0;
                exp_bad  = 0;
            end
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: every word the DUT presents must match the head of the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h with nothing expected (t=%0t)", out_data, $time);
            end else begin
                e = sb.pop_front();
                chk("data", 64'(out_data), 64'(e.data));
                chk("keep", 64'(out_keep), 64'(e.keep));
                chk("sop",  64'(out_sop),  64'(e.sop));
                chk("eop",  64'(out_eop),  64'(e.eop));
                if (e.eop) begin
                    chk("err",       64'(out_err),   64'(e.err));
                    chk("frame_len", 64'(frame_len), 64'(e.len));
                    chk("good_cnt",  64'(good_cnt),  64'(e.good));
                    chk("bad_cnt",   64'(bad_cnt),   64'(e.bad));
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int waited;
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_reset_state("reset");

        // good 64-byte frame
        make_frame(60, 3);   push_expect(1'b0, 9999); send(-1, -1, 12);
        // good 65-byte frame: final word keep=1, upper lanes zero
        make_frame(61, 5);   push_expect(1'b0, 9999); send(-1, -1, 12);
        // payload bit flipped after FCS computed
        make_frame(60, 3);   fr[10] = fr[10] ^ 8'h04;
        push_expect(1'b1, 9999); send(-1, -1, 12);
        // rx_er on byte 20
        make_frame(60, 7);   push_expect(1'b1, 9999); send(20, -1, 12);
        // runt with valid CRC
        make_frame(56, 9);   push_expect(1'b1, 9999); send(-1, -1, 12);
        // oversize with valid CRC
        make_frame(1515, 1); push_expect(1'b1, 9999); send(-1, -1, 12);
        // back-to-back, one idle cycle between
        make_frame(60, 11);  push_expect(1'b0, 9999); send(-1, -1, 1);
        make_frame(60, 13);  push_expect(1'b0, 9999); send(-1, -1, 12);
        // bad preamble: everything after 0x12 must be ignored until dv drops
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'h12, 1'b0);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'hD5, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        // reset at byte 30: words 0..6 already out, nothing after
        make_frame(60, 1);   push_expect(1'b0, 7); send(-1, 30, 12);
        // next frame received normally from zeroed counters
        make_frame(60, 3);   push_expect(1'b0, 9999); send(-1, -1, 12);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_framer.md
# gmii_rx_framer

Receive-side frame delineator in the `gmii_rx_clk` domain, sitting directly behind the RGMII-to-GMII receive path. It strips preamble/SFD and packs payload bytes into parametrised-width words with start/end/keep markers. It checks FCS (CRC-32), length bounds and `gmii_rx_er`, and keeps good/bad frame counters. It is a pure streaming sink with no backpressure, because the PHY cannot be stalled.

## Interface
- `DATA_W`, 32, output word width in bits; legal values are 8, 16, 32 and 64.
- `MIN_LEN`, 64, minimum legal frame length in bytes (DA through FCS).
- `MAX_LEN`, 1518, maximum legal frame length in bytes.
- `CNT_W`, 32, width of the statistics counters.
- `clk`  in  1  GMII receive clock (`gmii_rx_clk`), the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `gmii_rx_dv`  in  1  GMII receive data valid.
- `gmii_rx_er`  in  1  GMII receive error.
- `gmii_rxd`  in  8  GMII receive byte.
- `out_valid`  out  1  word valid, one-cycle qualifier.
- `out_data`  out  DATA_W  packed bytes; the first byte of a word is in [7:0].
- `out_keep`  out  DATA_W/8  byte-lane enables, contiguous from lane 0.
- `out_sop`  out  1  first word of the frame.
- `out_eop`  out  1  last word of the frame.
- `out_err`  out  1  frame bad; meaningful only with `out_eop`.
- `frame_len`  out  16  byte count of the last frame, updated with `out_eop`, saturates at 16'hFFFF.
- `good_cnt`  out  CNT_W  count of frames ending without error; wraps.
- `bad_cnt`  out  CNT_W  count of frames ending with error or aborted after SFD; wraps.

## Operation
- **Input stage.** `gmii_rx_dv/er/rxd` are registered once into `dv_d/er_d/rxd_d`. The live `gmii_rx_dv` is used as a one-byte look-ahead for end of frame.

**State machine** (evaluated on `dv_d`, `rxd_d`):
- **IDLE**
  - `dv_d`=1 with 0x55 → PRE.
  - `dv_d`=1 with any other byte → DROP.
- **PRE**
  - 0x55 stays in PRE.
  - 0xD5 → DATA. CRC is set to 0xFFFFFFFF, length to 0, and `first`=1.
  - Any other byte → DROP.
  - `dv_d`=0 → IDLE with no output and no count.
- **DATA**
  - Each byte is shifted into the pack register at lane `lane`, the CRC is updated, length increments (saturating), and `er_d` is ORed into a sticky error.
  - A word is emitted when lane = DATA_W/8-1, or when the byte is the last one (`gmii_rx_dv`=0).
  - On the last byte the state goes → IDLE.
- **DROP**
  - Waits for `dv_d`=0, then → IDLE. Emits nothing and counts nothing.

**Word emission and end of frame:**
- `out_sop` is set on the first word after SFD.
- `out_eop` is set on the word holding the last byte.
- `out_keep` = lanes filled; all ones on non-final words.
- `out_err` = sticky rx_er, OR CRC residue ≠ 0xC704DD7B, OR `frame_len`<MIN_LEN, OR `frame_len`>MAX_LEN.
- The good or bad counter increments in the same cycle as `out_eop`.
- A frame carrying an FCS is passed through with the FCS included; there is no stripping.
- Unused lanes of `out_data` on a partial word are 0.

**Arithmetic:**
- CRC-32 uses the reflected polynomial 0xEDB88320, processes one byte per cycle, and has no final XOR before the residue compare.
- Length is 16-bit and saturating.
- Counters are CNT_W wide and modulo 2^CNT_W.

## Timing
- **Reset values:** all outputs are 0, and the state is IDLE.
- **Reset mid-frame:** the frame is discarded with no eop and no count. Remaining bytes of that frame fall into DROP (the first byte seen is not 0x55 or 0xD5) or PRE; a payload starting with 0x55 can be misframed, which is acceptable.
- **Latency:** `out_valid` is asserted 2 cycles after the GMII byte that completes the word (1 cycle input register, 1 cycle output register).
- **Output pulses:** `out_valid` and the markers are single-cycle pulses. Words of one frame are DATA_W/8 cycles apart.
- **Single-word frame:** a frame of ≤DATA_W/8 bytes gets `out_sop` and `out_eop` on the same beat.
- **Back-to-back frames:** a 1-cycle `dv` gap must be handled, and the next frame is framed correctly. The eop beat never collides with the next sop because PRE consumes at least 2 bytes.
- **rx_er timing:** `gmii_rx_er` asserted in PRE or IDLE has no effect. In DATA it marks the frame bad.
- **Abort in PRE:** `dv` dropping in PRE (preamble only) produces no count.

## Structure
- Package `eth_rx_pkg`:
  - state enum (IDLE/PRE/DATA/DROP)
  - constants `ETH_PREAMBLE`=8'h55, `ETH_SFD`=8'hD5, `CRC32_RESIDUE`=32'hC704DD7B, `CRC32_INIT`
  - function `crc32_byte(crc, byte)`
- One sub-module, `gmii_byte_packer`: lane counter, pack register and keep generation. The FSM, CRC, length and counters stay in the top.

## Test plan
- Valid 64-byte frame with correct FCS (7×0x55, 0xD5), DATA_W=32:
  - 16 words; sop on word 0 and eop on word 15 with keep=4'hF.
  - `out_err`=0, `frame_len`=64, `good_cnt`=1.
- 65-byte frame, DATA_W=32: last word has keep=4'h1 and data[31:8]=0.
- Same 64-byte frame with one payload bit flipped, then a separate frame with `gmii_rx_er` pulsed on byte 20: each gives `out_err`=1 at eop and `bad_cnt` increments by 1.
- Runt and long frames, each with valid CRC:
  - 60 bytes → err=1, `frame_len`=60.
  - 1519 bytes → err=1, `frame_len`=1519.
- Two valid frames separated by a 1-cycle `dv` gap: two sop/eop pairs and `good_cnt`=2. Then a preamble of 0x55,0x55,0x12 → no output and DROP until `dv`=0.
- `rst` pulsed at byte 30 of a frame: outputs go to 0 the next cycle, no eop, counters 0. The following valid frame is received normally.
